// File: rtl/std_sram_64d128x_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// std_sram_64d128x_port_ctrl_if
// Bundles the three channels of the SRAM port controller:
//   request  : req_valid/req_ready handshake, req_write, req_addr,
//              req_wdata, req_wmask (per-bit write enable)
//   response : rsp_valid/rsp_ready handshake, rsp_rdata (read data)
//   sram     : sram_en, sram_we, sram_addr, sram_bwe, sram_din towards the
//              64x128 wrapper, sram_dout back from it (1-cycle read latency)
// Modports:
//   slave  - the controller
//   master - the environment (requester, response consumer, SRAM wrapper)
// ---------------------------------------------------------------------------
interface std_sram_64d128x_port_ctrl_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [5:0]   req_addr;
    logic [127:0] req_wdata;
    logic [127:0] req_wmask;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;

    logic         sram_en;
    logic         sram_we;
    logic [5:0]   sram_addr;
    logic [127:0] sram_bwe;
    logic [127:0] sram_din;
    logic [127:0] sram_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  rsp_ready, sram_dout,
        output req_ready, rsp_valid, rsp_rdata,
        output sram_en, sram_we, sram_addr, sram_bwe, sram_din
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        output rsp_ready, sram_dout,
        input  req_ready, rsp_valid, rsp_rdata,
        input  sram_en, sram_we, sram_addr, sram_bwe, sram_din
    );
endinterface

// File: rtl/std_sram_64d128x_port_ctrl.sv
// ---------------------------------------------------------------------------
// std_sram_64d128x_port_ctrl
// Request/response front-end for the single-port 64x128 bit-write-enable
// SRAM wrapper. Accepted requests are issued to the SRAM combinationally in
// the acceptance cycle; read data returns one cycle later and is captured in
// a RSP_DEPTH-entry response FIFO that feeds the response channel in request
// order. Writes produce no response.
// Ports:
//   clk   - single rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - request, response and SRAM channels (slave modport)
// Parameters:
//   RSP_DEPTH - response FIFO entries (>=2; >=3 sustains one read per cycle)
// ---------------------------------------------------------------------------
module std_sram_64d128x_port_ctrl #(
    parameter int RSP_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    std_sram_64d128x_port_ctrl_if.slave    bus
);
    localparam int DATA_W = 128;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_W:0]   DEPTH_CREDIT = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(RSP_DEPTH - 1);

    logic                 rd_inflight;
    logic [CNT_W-1:0]     fifo_count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_W-1:0]    fifo_mem [RSP_DEPTH];

    logic [CNT_W:0]       credit_used;
    logic                 req_ready;
    logic                 accept;
    logic                 accept_rd;
    logic                 push;
    logic                 pop;
    logic                 rsp_valid;

    // Pointers wrap at RSP_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Read credit covers both stored entries and the read whose data is
    // still on its way out of the SRAM, so a push can never find the FIFO
    // full. Writes need no credit and are always ready.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight};
        req_ready   = !reset && (bus.req_write || (credit_used < DEPTH_CREDIT));
        accept      = bus.req_valid && req_ready;
        accept_rd   = accept && !bus.req_write;
        rsp_valid   = (fifo_count != '0);
        push        = rd_inflight;
        pop         = rsp_valid && bus.rsp_ready;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = fifo_mem[rd_ptr];

    // Issue happens in the acceptance cycle; sram_en is gated by req_ready,
    // which is low during reset, so a reset kills any access immediately.
    assign bus.sram_en   = accept;
    assign bus.sram_we   = bus.req_write;
    assign bus.sram_addr = bus.req_addr;
    assign bus.sram_din  = bus.req_wdata;
    assign bus.sram_bwe  = bus.req_write ? bus.req_wmask : '0;

    // Stage 0 -> 1: read issued, data appears on sram_dout next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= accept_rd;
        end
    end

    // Stage 1 -> 2: capture read data into the response FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.sram_dout;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count == DEPTH_CNT)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && (fifo_count == '0)));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credit_used <= DEPTH_CREDIT);

endmodule

// File: tb/tb_std_sram_64d128x_port_ctrl.sv
module tb_std_sram_64d128x_port_ctrl;
    logic clk;
    logic reset;
    logic clr_mem;
    int   cyc;

    int n_cmp  = 0;
    int n_fail = 0;

    std_sram_64d128x_port_ctrl_if bus();

    std_sram_64d128x_port_ctrl #(.RSP_DEPTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 64x128 SRAM wrapper, 1-cycle read latency, bit write enable.
    logic [127:0] sram_mem [64];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= '0;
        end else if (bus.sram_en) begin
            if (bus.sram_we)
                sram_mem[bus.sram_addr] <= (sram_mem[bus.sram_addr] & ~bus.sram_bwe)
                                         | (bus.sram_din & bus.sram_bwe);
            else
                bus.sram_dout <= sram_mem[bus.sram_addr];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected read data queued at acceptance, compared at pop.
    logic [127:0] exp_q [$];
    int           pop_cyc [$];
    logic [127:0] drv_exp;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_extra: got response %h, required none", bus.rsp_rdata);
                end else begin
                    check("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
            if (bus.req_valid && bus.req_ready && !bus.req_write)
                exp_q.push_back(drv_exp);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_req(input bit wr, input logic [5:0] a, input logic [127:0] d,
                          input logic [127:0] m, input logic [127:0] e,
                          input int max_wait, output int waits);
        bit done;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        drv_exp       = e;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (bus.req_ready) begin
                check("issue_en",   bus.sram_en,   1'b1);
                check("issue_we",   bus.sram_we,   wr);
                check("issue_addr", bus.sram_addr, a);
                check("issue_bwe",  bus.sram_bwe,  wr ? m : 128'd0);
                if (wr) check("issue_din", bus.sram_din, d);
                done = 1;
            end else begin
                waits++;
                if (waits > max_wait) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL req_timeout: addr %0d not accepted after %0d cycles", a, waits);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] pat(input int i);
        return {4{32'hC0DE_0000 | i}};
    endfunction

    typedef struct {
        bit           wr;
        logic [5:0]   addr;
        logic [127:0] wdata;
        logic [127:0] wmask;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int n;

        vecs[0] = '{1'b1, 6'd5,  {16{8'hA5}}, {128{1'b1}}, 128'd0};
        vecs[1] = '{1'b0, 6'd5,  128'd0, 128'd0, {16{8'hA5}}};
        vecs[2] = '{1'b1, 6'd9,  {128{1'b1}}, {112'd0, 16'hFFFF}, 128'd0};
        vecs[3] = '{1'b0, 6'd9,  128'd0, 128'd0, {112'd0, 16'hFFFF}};
        vecs[4] = '{1'b1, 6'd12, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    {{64{1'b1}}, 64'd0}, 128'd0};
        vecs[5] = '{1'b0, 6'd12, 128'd0, 128'd0, {64'h0123_4567_89AB_CDEF, 64'd0}};
        vecs[6] = '{1'b1, 6'd63, {128{1'b1}}, {128{1'b1}}, 128'd0};
        vecs[7] = '{1'b0, 6'd63, 128'd0, 128'd0, {128{1'b1}}};
        vecs[8] = '{1'b0, 6'd0,  128'd0, 128'd0, 128'd0};

        cyc           = 0;
        reset         = 1'b1;
        clr_mem       = 1'b1;
        drv_exp       = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, with a read request offered during reset.
        bus.req_valid = 1'b1;
        #1;
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_sram_en",   bus.sram_en,   1'b0);
        bus.req_valid = 1'b0;
        clr_mem = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Write then read addr 5: first accept right after reset, 2-cycle latency.
        do_req(1'b1, 6'd5, {16{8'hA5}}, {128{1'b1}}, 128'd0, 0, w);
        check("first_accept_wait", w, 0);
        do_req(1'b0, 6'd5, 128'd0, 128'd0, {16{8'hA5}}, 0, w);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_rsp_valid", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t2_rsp_valid", bus.rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        idle_cycles(2);

        // Table of back-to-back requests with fixed expected read data.
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].exp, 3, w);
            check("tbl_wait", w, 0);
        end
        idle_cycles(4);
        check("tbl_drain", exp_q.size(), 0);

        // Back-to-back reads 0..7 with rsp_ready=1.
        for (int i = 0; i < 8; i++)
            do_req(1'b1, 6'(i), pat(i), {128{1'b1}}, 128'd0, 0, w);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 6'(i), 128'd0, 128'd0, pat(i), 3, w);
            check("b2b_ready_wait", w, 0);
        end
        idle_cycles(5);
        check("b2b_drain", exp_q.size(), 0);
        n = pop_cyc.size();
        if (n >= 8) check("b2b_consecutive", pop_cyc[n-1] - pop_cyc[n-8], 7);
        else        check("b2b_count", n, 8);

        // Backpressure: three reads fill the credit, a fourth is blocked,
        // a write still flows, then draining lets reads resume.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 6'(i), 128'd0, 128'd0, pat(i), 0, w);
            check("bp_fill_wait", w, 0);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd3;
        #1;
        check("bp_rd_blocked", bus.req_ready, 1'b0);
        do_req(1'b1, 6'd40, pat(40), {128{1'b1}}, 128'd0, 0, w);
        check("bp_wr_flow_wait", w, 0);
        check("bp_rsp_held", bus.rsp_valid, 1'b1);
        fork
            do_req(1'b0, 6'd3, 128'd0, 128'd0, pat(3), 20, w);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
            end
        join
        check("bp_resume_waited", (w >= 3), 1'b1);
        do_req(1'b0, 6'd4,  128'd0, 128'd0, pat(4),  5, w);
        do_req(1'b0, 6'd40, 128'd0, 128'd0, pat(40), 5, w);
        idle_cycles(5);
        check("bp_drain", exp_q.size(), 0);

        // Reset with two FIFO entries plus one read in flight.
        do_req(1'b1, 6'd20, pat(20), {128{1'b1}}, 128'd0, 0, w);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            do_req(1'b0, 6'(i), 128'd0, 128'd0, pat(i), 0, w);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'd7;
        reset = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_sram_en",   bus.sram_en,   1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b0);
        exp_q.delete();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_stale", bus.rsp_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 6'd20, 128'd0, 128'd0, pat(20), 0, w);
        check("postrst_accept_wait", w, 0);
        idle_cycles(4);
        check("postrst_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
